// File: rtl/cosim_cmd_engine_if.sv
// rtl/cosim_cmd_engine_if.sv - UART-side byte link (rx command bytes in, tx response bytes out)
interface cosim_cmd_engine_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;

  modport slave (
    input  rx_data_i, rx_valid_i, tx_ready_i,
    output rx_ready_o, tx_data_o, tx_valid_o
  );

  modport master (
    output rx_data_i, rx_valid_i, tx_ready_i,
    input  rx_ready_o, tx_data_o, tx_valid_o
  );
endinterface

// File: rtl/cosim_cmd_engine.sv
// rtl/cosim_cmd_engine.sv - Byte-command engine driving loader FIFOs, start, PMU reads and idle polling
module cosim_cmd_engine #(
  parameter int CORE_COUNT   = 16,
  parameter int AXI_ID_WIDTH = 5,
  parameter int PMU_ADDR_W   = 5,
  parameter int PMU_DATA_W   = 64,
  parameter int PMU_LAT      = 1
) (
  input  logic                                   clk_i,
  input  logic                                   arst_i,
  cosim_cmd_engine_if.slave                      link,
  output logic [CORE_COUNT-1:0][PMU_ADDR_W-1:0]   pmu_addr_o,
  input  logic [CORE_COUNT-1:0][PMU_DATA_W-1:0]   pmu_data_i,
  output logic [7:0]                             req_depth_o,
  output logic [CORE_COUNT-1:0][AXI_ID_WIDTH-1:0] id_o,
  output logic [CORE_COUNT-1:0]                  write_o,
  output logic [CORE_COUNT-1:0][7:0]             axlen_o,
  output logic [CORE_COUNT-1:0]                  fifo_push_o,
  output logic                                   start_o,
  input  logic [CORE_COUNT-1:0]                  idle_i
);
  localparam int IDLE_BYTES = (CORE_COUNT + 7) / 8;
  localparam int PMU_BYTES  = PMU_DATA_W / 8;
  localparam int RSP_BYTES  = (PMU_BYTES > IDLE_BYTES) ? PMU_BYTES : IDLE_BYTES;
  localparam int RSP_W      = RSP_BYTES * 8;
  localparam int CNT_W      = $clog2(RSP_BYTES + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARGS     = 3'd1;
  localparam logic [2:0] S_EXEC     = 3'd2;
  localparam logic [2:0] S_PMU_WAIT = 3'd3;
  localparam logic [2:0] S_SEND     = 3'd4;

  localparam logic [7:0] OP_SET_DEPTH = 8'h01;
  localparam logic [7:0] OP_PUSH      = 8'h02;
  localparam logic [7:0] OP_START     = 8'h03;
  localparam logic [7:0] OP_READ_PMU  = 8'h04;
  localparam logic [7:0] OP_POLL_IDLE = 8'h05;
  localparam logic [7:0] RSP_ACK      = 8'hA5;
  localparam logic [7:0] RSP_NAK      = 8'hEE;
  localparam logic [7:0] CORE_BCAST   = 8'hFF;

  logic [2:0]            state;
  logic [7:0]            opcode;
  logic [3:0][7:0]       args;
  logic [1:0]            arg_idx;
  logic [1:0]            arg_last;
  logic [2:0]            wait_cnt;
  logic [7:0]            pmu_core;
  logic [RSP_W-1:0]      rsp_shift;
  logic [CNT_W-1:0]      rsp_cnt;
  logic                  tx_valid;
  logic [CORE_COUNT-1:0] push_pend;
  logic [PMU_DATA_W-1:0] pmu_sel;
  logic                  core_ok;
  logic                  bcast;
  logic                  unused_arg_bits;

  function automatic logic [2:0] arg_count(input logic [7:0] op);
    case (op)
      OP_SET_DEPTH: arg_count = 3'd1;
      OP_PUSH:      arg_count = 3'd4;
      OP_READ_PMU:  arg_count = 3'd2;
      default:      arg_count = 3'd0;
    endcase
  endfunction

  function automatic logic op_known(input logic [7:0] op);
    op_known = (op >= OP_SET_DEPTH) && (op <= OP_POLL_IDLE);
  endfunction

  assign core_ok         = int'(args[0]) < CORE_COUNT;
  assign bcast           = args[0] == CORE_BCAST;
  assign unused_arg_bits = ^{args[1], args[2]};

  assign link.rx_ready_o = !arst_i && ((state == S_IDLE) || (state == S_ARGS));
  assign link.tx_valid_o = tx_valid;
  assign link.tx_data_o  = rsp_shift[7:0];

  always_comb begin
    pmu_sel = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      if (pmu_core == 8'(i)) pmu_sel = pmu_data_i[i];
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state       <= S_IDLE;
      opcode      <= '0;
      args        <= '0;
      arg_idx     <= '0;
      arg_last    <= '0;
      wait_cnt    <= '0;
      pmu_core    <= '0;
      rsp_shift   <= '0;
      rsp_cnt     <= '0;
      tx_valid    <= 1'b0;
      push_pend   <= '0;
      pmu_addr_o  <= '0;
      req_depth_o <= '0;
      id_o        <= '0;
      write_o     <= '0;
      axlen_o     <= '0;
      fifo_push_o <= '0;
      start_o     <= 1'b0;
    end else begin
      // Push strobe trails the register load by one cycle so loaders see stable data.
      push_pend   <= '0;
      fifo_push_o <= push_pend;
      start_o     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (link.rx_valid_i) begin
            opcode  <= link.rx_data_i;
            arg_idx <= '0;
            if (!op_known(link.rx_data_i)) begin
              rsp_shift <= RSP_W'(RSP_NAK);
              rsp_cnt   <= CNT_W'(1);
              state     <= S_SEND;
            end else if (arg_count(link.rx_data_i) == 3'd0) begin
              state <= S_EXEC;
            end else begin
              arg_last <= 2'(arg_count(link.rx_data_i) - 3'd1);
              state    <= S_ARGS;
            end
          end
        end

        S_ARGS: begin
          if (link.rx_valid_i) begin
            args[arg_idx] <= link.rx_data_i;
            arg_idx       <= arg_idx + 2'd1;
            if (arg_idx == arg_last) state <= S_EXEC;
          end
        end

        S_EXEC: begin
          rsp_shift <= RSP_W'(RSP_ACK);
          rsp_cnt   <= CNT_W'(1);
          state     <= S_SEND;
          case (opcode)
            OP_SET_DEPTH: req_depth_o <= args[0];
            OP_PUSH: begin
              if (bcast || core_ok) begin
                for (int i = 0; i < CORE_COUNT; i++) begin
                  if (bcast || (args[0] == 8'(i))) begin
                    id_o[i]      <= args[1][AXI_ID_WIDTH-1:0];
                    write_o[i]   <= args[2][0];
                    axlen_o[i]   <= args[3];
                    push_pend[i] <= 1'b1;
                  end
                end
              end else begin
                rsp_shift <= RSP_W'(RSP_NAK);
              end
            end
            OP_START: start_o <= 1'b1;
            OP_READ_PMU: begin
              if (core_ok) begin
                for (int i = 0; i < CORE_COUNT; i++) begin
                  if (args[0] == 8'(i)) pmu_addr_o[i] <= args[1][PMU_ADDR_W-1:0];
                end
                pmu_core <= args[0];
                wait_cnt <= '0;
                state    <= S_PMU_WAIT;
              end else begin
                rsp_shift <= RSP_W'(RSP_NAK);
              end
            end
            default: begin
              rsp_shift <= RSP_W'(idle_i);
              rsp_cnt   <= CNT_W'(IDLE_BYTES);
            end
          endcase
        end

        S_PMU_WAIT: begin
          if (wait_cnt == 3'(PMU_LAT)) begin
            rsp_shift <= RSP_W'(pmu_sel);
            rsp_cnt   <= CNT_W'(PMU_BYTES);
            state     <= S_SEND;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end

        S_SEND: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
          end else if (link.tx_ready_i) begin
            rsp_shift <= rsp_shift >> 8;
            rsp_cnt   <= rsp_cnt - CNT_W'(1);
            if (rsp_cnt == CNT_W'(1)) begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cosim_cmd_engine.sv
// tb/tb_cosim_cmd_engine.sv - Scoreboarded directed and random bench for cosim_cmd_engine
module tb_cosim_cmd_engine;
  localparam int NC = 16, NCB = 12, PLAT = 2, PLATB = 0, IW = 5, AW = 5, DW = 64;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  cosim_cmd_engine_if bus_a ();
  cosim_cmd_engine_if bus_b ();

  logic [NC-1:0][AW-1:0]  paddr_a, p1_a, p2_a, m_paddr;
  logic [NC-1:0][DW-1:0]  pdata_a;
  logic [7:0]             depth_a, m_depth;
  logic [NC-1:0][IW-1:0]  id_a, m_id;
  logic [NC-1:0]          wr_a, push_a, idle_a, m_wr;
  logic [NC-1:0][7:0]     len_a, m_len;
  logic                   start_a;

  logic [NCB-1:0][AW-1:0] paddr_b;
  logic [NCB-1:0][DW-1:0] pdata_b;
  logic [7:0]             depth_b;
  logic [NCB-1:0][IW-1:0] id_b;
  logic [NCB-1:0]         wr_b, push_b, idle_b;
  logic [NCB-1:0][7:0]    len_b;
  logic                   start_b;

  cosim_cmd_engine #(.CORE_COUNT(NC), .AXI_ID_WIDTH(IW), .PMU_ADDR_W(AW), .PMU_DATA_W(DW), .PMU_LAT(PLAT)) dut_a (
    .clk_i(clk), .arst_i(arst), .link(bus_a), .pmu_addr_o(paddr_a), .pmu_data_i(pdata_a),
    .req_depth_o(depth_a), .id_o(id_a), .write_o(wr_a), .axlen_o(len_a), .fifo_push_o(push_a),
    .start_o(start_a), .idle_i(idle_a));

  cosim_cmd_engine #(.CORE_COUNT(NCB), .AXI_ID_WIDTH(IW), .PMU_ADDR_W(AW), .PMU_DATA_W(DW), .PMU_LAT(PLATB)) dut_b (
    .clk_i(clk), .arst_i(arst), .link(bus_b), .pmu_addr_o(paddr_b), .pmu_data_i(pdata_b),
    .req_depth_o(depth_b), .id_o(id_b), .write_o(wr_b), .axlen_o(len_b), .fifo_push_o(push_b),
    .start_o(start_b), .idle_i(idle_b));

  int n_tests = 0, n_fail = 0;

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event seen with nothing expected", name);
  endfunction

  // PMU register contents as a function of core and address
  function automatic logic [63:0] pmu_val(input int c, input int a);
    logic [31:0] lo;
    if (c == 5 && a == 2) return 64'h0123456789ABCDEF;
    lo = 32'(c * 4099 + a * 131 + 7);
    return {8'(c), 8'(a), 16'h5A3C, lo ^ 32'hDEAD0000};
  endfunction

  always @(posedge clk) begin
    p1_a <= paddr_a;
    p2_a <= p1_a;
  end

  always_comb begin
    pdata_a = '0;
    for (int c = 0; c < NC; c++) pdata_a[c] = pmu_val(c, int'(p2_a[c]));
  end

  always_comb begin
    pdata_b = '0;
    for (int c = 0; c < NCB; c++) pdata_b[c] = pmu_val(c, int'(paddr_b[c]));
  end

  typedef struct packed {
    logic [NC-1:0]         mask;
    logic [NC-1:0][IW-1:0] id;
    logic [NC-1:0]         wr;
    logic [NC-1:0][7:0]    len;
  } push_t;

  logic [7:0] exp_tx_a[$];
  logic [7:0] exp_tx_b[$];
  int         exp_lat_a[$];
  push_t      exp_push[$];
  int         starts_seen = 0, starts_exp = 0;

  bit bp_on = 1'b0;
  logic last_a = 1'b0, last_b = 1'b0;

  always @(posedge clk) begin
    #1;
    bus_a.tx_ready_i = bp_on ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int hs_edge_a = 0;
  logic prev_v_a = 1'b0, prev_hold_a = 1'b0;
  logic [7:0] prev_d_a = '0;
  push_t pe;

  always @(negedge clk) begin
    if (arst) begin
      prev_v_a = 1'b0;
      prev_hold_a = 1'b0;
    end else begin
      if (bus_a.rx_valid_i && bus_a.rx_ready_o && last_a) hs_edge_a = cyc + 1;
      if (bus_a.tx_valid_o && !prev_v_a) begin
        if (exp_lat_a.size() == 0) flag("lat_a_unexpected");
        else chk("resp_latency_a", 256'(cyc - hs_edge_a), 256'(exp_lat_a.pop_front()));
      end
      if (prev_hold_a) chk("tx_hold_a", {bus_a.tx_valid_o, bus_a.tx_data_o}, {1'b1, prev_d_a});
      if (bus_a.tx_valid_o && bus_a.tx_ready_i) begin
        if (exp_tx_a.size() == 0) flag("tx_a_unexpected");
        else chk("tx_byte_a", bus_a.tx_data_o, exp_tx_a.pop_front());
      end
      if (push_a != '0) begin
        if (exp_push.size() == 0) flag("push_a_unexpected");
        else begin
          pe = exp_push.pop_front();
          chk("push_a", {push_a, id_a, wr_a, len_a}, pe);
        end
      end
      if (start_a) starts_seen++;
      prev_v_a = bus_a.tx_valid_o;
      prev_hold_a = bus_a.tx_valid_o && !bus_a.tx_ready_i;
      prev_d_a = bus_a.tx_data_o;
    end
  end

  always @(negedge clk) begin
    if (!arst) begin
      if (bus_b.tx_valid_o && bus_b.tx_ready_i) begin
        if (exp_tx_b.size() == 0) flag("tx_b_unexpected");
        else chk("tx_byte_b", bus_b.tx_data_o, exp_tx_b.pop_front());
      end
      if (push_b != '0) flag("push_b_unexpected");
    end
  end

  task automatic exp_byte(input bit sel, input logic [7:0] b);
    if (sel) exp_tx_b.push_back(b);
    else exp_tx_a.push_back(b);
  endtask

  // Called and returns at posedge+1
  task automatic send_byte(input bit sel, input logic [7:0] b, input bit last);
    logic rdy;
    int n;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    if (sel) begin bus_b.rx_data_i = b; bus_b.rx_valid_i = 1'b1; last_b = last; end
    else begin bus_a.rx_data_i = b; bus_a.rx_valid_i = 1'b1; last_a = last; end
    n = 0;
    do begin
      @(negedge clk);
      rdy = sel ? bus_b.rx_ready_o : bus_a.rx_ready_o;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 3000);
    if (!rdy) flag("rx_accept_timeout");
    bus_a.rx_valid_i = 1'b0; bus_b.rx_valid_i = 1'b0;
    last_a = 1'b0; last_b = 1'b0;
  endtask

  task automatic cmd(input bit sel, input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1,
                     input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] a [4];
    logic [63:0] w;
    logic [NC-1:0] idl;
    push_t e;
    int na, nc, plat, n;
    a = '{a0, a1, a2, a3};
    nc = sel ? NCB : NC;
    plat = sel ? PLATB : PLAT;
    na = (op == 8'h01) ? 1 : (op == 8'h02) ? 4 : (op == 8'h04) ? 2 : 0;
    case (op)
      8'h01: begin
        if (!sel) m_depth = a0;
        exp_byte(sel, 8'hA5);
        if (!sel) exp_lat_a.push_back(2);
      end
      8'h02: begin
        if (a0 == 8'hFF || a0 < nc) begin
          e = '0;
          for (int c = 0; c < NC; c++) begin
            if (a0 == 8'hFF || a0 == 8'(c)) begin
              m_id[c] = a1[IW-1:0]; m_wr[c] = a2[0]; m_len[c] = a3; e.mask[c] = 1'b1;
            end
          end
          e.id = m_id; e.wr = m_wr; e.len = m_len;
          if (!sel) exp_push.push_back(e);
          exp_byte(sel, 8'hA5);
        end else exp_byte(sel, 8'hEE);
        if (!sel) exp_lat_a.push_back(2);
      end
      8'h03: begin
        if (!sel) starts_exp++;
        exp_byte(sel, 8'hA5);
        if (!sel) exp_lat_a.push_back(2);
      end
      8'h04: begin
        if (a0 < nc) begin
          if (!sel) m_paddr[a0] = a1[AW-1:0];
          w = pmu_val(int'(a0), int'(a1[AW-1:0]));
          for (int k = 0; k < DW / 8; k++) exp_byte(sel, w[8*k +: 8]);
          if (!sel) exp_lat_a.push_back(plat + 3);
        end else begin
          exp_byte(sel, 8'hEE);
          if (!sel) exp_lat_a.push_back(2);
        end
      end
      8'h05: begin
        idl = '0;
        if (sel) idl[NCB-1:0] = idle_b; else idl = idle_a;
        for (int k = 0; k < (nc + 7) / 8; k++) exp_byte(sel, idl[8*k +: 8]);
        if (!sel) exp_lat_a.push_back(2);
      end
      default: begin
        exp_byte(sel, 8'hEE);
        if (!sel) exp_lat_a.push_back(1);
      end
    endcase
    send_byte(sel, op, na == 0);
    for (int i = 0; i < na; i++) send_byte(sel, a[i], i == na - 1);
    n = 0;
    while ((sel ? exp_tx_b.size() : exp_tx_a.size()) != 0 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) flag("response_timeout");
    repeat (3) begin @(posedge clk); #1; end
    if (!sel) begin
      chk("req_depth", depth_a, m_depth);
      chk("pmu_addr", paddr_a, m_paddr);
      chk("id_wr_len", {id_a, wr_a, len_a}, {m_id, m_wr, m_len});
      chk("start_count", 256'(starts_seen), 256'(starts_exp));
      chk("push_drained", 256'(exp_push.size()), 256'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_regs"}, {depth_a, paddr_a, id_a, wr_a}, '0);
    chk({tag, "_strobes"}, {len_a, push_a, start_a, bus_a.tx_valid_o, bus_a.rx_ready_o}, '0);
  endtask

  initial begin
    logic [7:0] op, x0, x1, x2, x3;
    int kind;
    bus_a.rx_data_i = '0; bus_a.rx_valid_i = 1'b0; bus_a.tx_ready_i = 1'b1;
    bus_b.rx_data_i = '0; bus_b.rx_valid_i = 1'b0; bus_b.tx_ready_i = 1'b1;
    idle_a = '0; idle_b = '0;
    m_depth = '0; m_id = '0; m_wr = '0; m_len = '0; m_paddr = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    arst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    cmd(0, 8'h01, 8'h08, 8'h00, 8'h00, 8'h00);

    // abort a command mid-argument; nothing may be transmitted afterwards
    send_byte(0, 8'h01, 1'b0);
    @(negedge clk);
    chk("args_rx_ready", bus_a.rx_ready_o, 1'b1);
    arst = 1'b1;
    #1;
    check_reset_outputs("mid_args_reset");
    m_depth = '0; m_id = '0; m_wr = '0; m_len = '0; m_paddr = '0;
    @(posedge clk); #1;
    arst = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    chk("post_reset_depth", depth_a, 8'h00);

    cmd(0, 8'h02, 8'h03, 8'h11, 8'h01, 8'h0F);
    cmd(0, 8'h02, 8'hFF, 8'h02, 8'h00, 8'h07);
    cmd(0, 8'h02, 8'h10, 8'h05, 8'h01, 8'h33);
    cmd(0, 8'h04, 8'h20, 8'h00, 8'h00, 8'h00);
    cmd(0, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00);
    cmd(0, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00);

    bp_on = 1'b1;
    cmd(0, 8'h04, 8'h05, 8'h02, 8'h00, 8'h00);
    idle_a = 16'h80F1;
    cmd(0, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00);
    bp_on = 1'b0;

    idle_b = 12'h0F1;
    cmd(1, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00);
    cmd(1, 8'h04, 8'h0B, 8'h03, 8'h00, 8'h00);
    cmd(1, 8'h02, 8'h0C, 8'h01, 8'h01, 8'h01);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      x0 = 8'($urandom); x1 = 8'($urandom); x2 = 8'($urandom); x3 = 8'($urandom);
      case (kind)
        0: op = 8'h01;
        1: begin op = 8'h02; x0 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 17)); end
        2: op = 8'h03;
        3: begin op = 8'h04; x0 = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 17)); end
        4: begin op = 8'h05; idle_a = 16'($urandom); end
        default: begin op = 8'($urandom_range(6, 255)); if (x0[0]) op = 8'h00; end
      endcase
      bp_on = $urandom_range(0, 1) == 1;
      cmd(0, op, x0, x1, x2, x3);
    end

    chk("tx_a_drained", 256'(exp_tx_a.size()), 256'd0);
    chk("tx_b_drained", 256'(exp_tx_b.size()), 256'd0);
    chk("lat_a_drained", 256'(exp_lat_a.size()), 256'd0);
    chk("b_untouched", {depth_b, start_b}, '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cosim_cmd_engine.md
Name: cosim_cmd_engine

Overview:
- Parametrised byte-command engine between a UART byte link and the traffic-loader mesh in the cosimulation top.
- Decodes host opcodes into loader FIFO pushes, request depth, start pulses, PMU reads and idle polling, then returns response bytes.
- Generalised over core count, ID width and PMU word width.
- Adds broadcast push, explicit ACK/NAK responses, and a PMU read latency parameter.

Parameters:
- CORE_COUNT, 16, number of loader channels; 1..254.
- AXI_ID_WIDTH, 5, width of the AXI ID pushed to loaders; 1..8.
- PMU_ADDR_W, 5, PMU register address width; 1..8.
- PMU_DATA_W, 64, PMU data width; multiple of 8.
- PMU_LAT, 1, cycles from pmu_addr_o change until pmu_data_i is valid; 0..3.

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous reset, active-high
- rx_data_i  in  8  byte from UART receiver
- rx_valid_i  in  1  rx byte valid
- rx_ready_o  out  1  engine accepts rx byte
- tx_data_o  out  8  byte to UART transmitter
- tx_valid_o  out  1  tx byte valid
- tx_ready_i  in  1  transmitter accepts byte
- pmu_addr_o  out  CORE_COUNT x PMU_ADDR_W  per-core PMU address
- pmu_data_i  in  CORE_COUNT x PMU_DATA_W  per-core PMU data
- req_depth_o  out  8  outstanding-request depth
- id_o  out  CORE_COUNT x AXI_ID_WIDTH  per-core push ID
- write_o  out  CORE_COUNT x 1  per-core push is write
- axlen_o  out  CORE_COUNT x 8  per-core push burst length
- fifo_push_o  out  CORE_COUNT x 1  per-core push strobe
- start_o  out  1  start pulse
- idle_i  in  CORE_COUNT x 1  per-core idle

Behaviour:
- Reset (async on arst_i rising edge, released synchronously): all outputs 0; rx_ready_o=0; tx_valid_o=0; FSM=IDLE; byte counters 0.
- Mid-operation reset aborts any command; no partial response is sent after reset.
- Handshakes: a byte transfers only when valid and ready are both 1. tx_data_o is held stable while tx_valid_o=1 and tx_ready_i=0.
- FSM states: IDLE, ARGS, EXEC, PMU_WAIT, SEND.
- IDLE: rx_ready_o=1. An accepted byte is the opcode:
  - Valid opcodes go to ARGS, with the argument count set by the opcode, or to EXEC if the count is 0.
  - An unknown opcode goes directly to SEND with the single byte 0xEE (NAK).
- ARGS: rx_ready_o=1; arguments are captured in order. After the last argument the FSM goes to EXEC. rx_ready_o=0 in every other state.
- Opcode 0x01 SET_DEPTH [d]: req_depth_o<=d; response 0xA5.
- Opcode 0x02 PUSH [core, id, flags, len]:
  - id_o[core]<=id[AXI_ID_WIDTH-1:0]; write_o[core]<=flags[0]; axlen_o[core]<=len.
  - fifo_push_o[core]=1 for exactly one cycle, in the cycle after the registers update, so data is stable when the push strobe is high.
  - core=0xFF is a broadcast: all channels are loaded and pushed in the same cycle.
  - core>=CORE_COUNT and not 0xFF: NAK, no push.
  - Response 0xA5.
- Opcode 0x03 START []: start_o=1 for exactly one cycle; response 0xA5.
- Opcode 0x04 READ_PMU [core, addr]:
  - core>=CORE_COUNT (including 0xFF): NAK.
  - Otherwise pmu_addr_o[core]<=addr, then PMU_WAIT for PMU_LAT+1 cycles.
  - pmu_data_i[core] is then latched into a shift register and PMU_DATA_W/8 bytes are sent, LSB byte first.
  - pmu_addr_o holds its value after the command.
- Opcode 0x05 POLL_IDLE []: idle_i is sampled in EXEC and ceil(CORE_COUNT/8) bytes are sent, byte 0 = cores 7..0. Unused bits are 0.
- SEND: bytes are emitted one per tx handshake. After the last handshake the FSM returns to IDLE, and a new opcode is accepted the next cycle.
- Latency:
  - ACK: tx_valid_o rises 2 cycles after the last argument handshake.
  - PMU: tx_valid_o rises PMU_LAT+3 cycles after the last argument handshake.
- Back-pressure: tx_ready_i=0 indefinitely stalls the engine in SEND with no loss. Rx bytes arriving meanwhile are not accepted (rx_ready_o=0).
- Widths: argument bytes wider than the target field are truncated to their LSBs. The response byte count is computed at elaboration.

Test Plan:
- Reset, then send 0x01 0x08 -> req_depth_o=8, tx byte 0xA5; assert arst_i mid-ARGS -> outputs 0, no tx.
- Push 0x02 0x03 0x11 0x01 0x0F -> one-cycle fifo_push_o[3] with id_o[3]=0x11, write_o[3]=1, axlen_o[3]=0x0F, other pushes 0, then 0xA5.
- Broadcast push 0x02 0xFF 0x02 0x00 0x07 -> all 16 fifo_push_o high in one cycle, all axlen_o=7.
- Send 0x02 0x10 ..., then 0x04 0x20 0x00, then opcode 0x7F -> three 0xEE bytes, no push, no pmu_addr_o change.
- pmu_data_i[5]=0x0123456789ABCDEF, send 0x04 0x05 0x02 with PMU_LAT=2 -> pmu_addr_o[5]=2, tx bytes EF CD AB 89 67 45 23 01, with tx_ready_i toggled randomly and no byte lost or repeated.
- idle_i=0x80F1 with CORE_COUNT=16, send 0x05 -> tx bytes F1 80; repeat with CORE_COUNT=12 -> F1 00, upper 4 bits 0.
